// File: rtl/ads1115_pkg.sv
// Shared types and constants for the ADS1115 scan sequencer: FSM states,
// register pointers and the config-register MSB field layout.
package ads1115_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_TICK,
    ST_LOAD,
    ST_REQ,
    ST_XFER,
    ST_STORE,
    ST_SETTLE,
    ST_ABORT
  } seq_state_t;

  localparam logic [7:0] CFG_PTR  = 8'h01;
  localparam logic [7:0] CONV_PTR = 8'h00;

  localparam logic [7:0] I2C_ON  = 8'h01;
  localparam logic [7:0] I2C_OFF = 8'h00;

  localparam logic [7:0] CFG_MSB_RESET = 8'hC3;
  localparam logic [7:0] CFG_LSB_RESET = 8'h83;

  // Config MSB layout: OS | MUX[2:0] | PGA[2:0] | MODE
  localparam int OS_BIT   = 7;
  localparam int MUX_HI   = 6;
  localparam int MUX_LO   = 4;
  localparam int PGA_HI   = 3;
  localparam int PGA_LO   = 1;
  localparam int MODE_BIT = 0;

  // Start a single-shot, single-ended conversion of AIN<ch> against GND.
  function automatic logic [7:0] cfg_msb(input logic [1:0] ch, input logic [2:0] pga);
    logic [7:0] w;
    w                 = '0;
    w[OS_BIT]         = 1'b1;
    w[MUX_HI:MUX_LO]  = {1'b1, ch};
    w[PGA_HI:PGA_LO]  = pga;
    w[MODE_BIT]       = 1'b1;
    return w;
  endfunction

  // Lowest set mask bit at or above start; result = {found, channel}.
  function automatic logic [2:0] find_channel(input logic [3:0] mask, input logic [2:0] start);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (i >= int'(start) && mask[i]) begin
        r = {1'b1, 2'(i)};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sample_period_timer.sv
// Scan period counter: emits a one-cycle tick every max(period,1) cycles and
// remembers at most one tick that lands while a scan is in progress.
module sample_period_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] period,
  input  logic        scan_busy,
  input  logic        take,
  output logic        tick,
  output logic        pending
);

  logic [31:0] cnt_reg;
  logic [31:0] limit;
  logic        tick_reg;
  logic        pending_reg;

  assign limit = (period == 32'd0) ? 32'd0 : period - 32'd1;

  // ">=" keeps the counter bounded if period shrinks below the current count.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      cnt_reg     <= '0;
      tick_reg    <= 1'b0;
      pending_reg <= 1'b0;
    end else begin
      if (cnt_reg >= limit) begin
        cnt_reg  <= '0;
        tick_reg <= 1'b1;
      end else begin
        cnt_reg  <= cnt_reg + 32'd1;
        tick_reg <= 1'b0;
      end
      if (tick_reg && scan_busy) begin
        pending_reg <= 1'b1;
      end else if (take) begin
        pending_reg <= 1'b0;
      end
    end
  end

  assign tick    = tick_reg;
  assign pending = pending_reg;

endmodule

// File: rtl/ads1115_scan_sequencer.sv
// Autonomous ADS1115 channel scanner: on each period tick walks the enabled
// AIN channels through the I2C core and reports each conversion result.
module ads1115_scan_sequencer
  import ads1115_pkg::*;
#(
  parameter logic [7:0]  DEV_ADDR = 8'h48,
  parameter int unsigned START_TO = 1024,
  parameter int unsigned XFER_TO  = 2000000,
  parameter int unsigned SETTLE   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] period,
  input  logic [3:0]  ch_mask,
  input  logic [2:0]  pga,
  input  logic [7:0]  cfg_lsb,
  input  logic        err_clr,
  input  logic        i2c_busy,
  input  logic [7:0]  i2c_a0m,
  input  logic [7:0]  i2c_a0l,
  output logic [7:0]  i2c_cam,
  output logic [7:0]  i2c_cal,
  output logic [7:0]  i2c_ad1,
  output logic [7:0]  i2c_ad2,
  output logic [7:0]  i2c_ad3,
  output logic [7:0]  i2c_write,
  output logic [7:0]  i2c_stop,
  output logic [15:0] result_data,
  output logic [1:0]  result_ch,
  output logic        result_valid,
  output logic        scan_done,
  output logic        timeout_err,
  output logic        seq_busy
);

  seq_state_t  state_reg;
  logic [1:0]  ch_reg;
  logic [31:0] tmr_reg;
  logic [7:0]  cam_reg;
  logic [7:0]  cal_reg;
  logic [7:0]  write_reg;
  logic [7:0]  stop_reg;
  logic [15:0] result_data_reg;
  logic [1:0]  result_ch_reg;
  logic        result_valid_reg;
  logic        scan_done_reg;
  logic        timeout_err_reg;

  logic        tick;
  logic        pending;
  logic [2:0]  first_pick;
  logic [2:0]  next_pick;

  assign seq_busy   = (state_reg != ST_IDLE) && (state_reg != ST_WAIT_TICK);
  assign first_pick = find_channel(ch_mask, 3'd0);
  assign next_pick  = find_channel(ch_mask, {1'b0, ch_reg} + 3'd1);

  sample_period_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .period    (period),
    .scan_busy (seq_busy),
    .take      (state_reg == ST_WAIT_TICK),
    .tick      (tick),
    .pending   (pending)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      ch_reg           <= '0;
      tmr_reg          <= '0;
      cam_reg          <= CFG_MSB_RESET;
      cal_reg          <= CFG_LSB_RESET;
      write_reg        <= I2C_OFF;
      stop_reg         <= I2C_OFF;
      result_data_reg  <= '0;
      result_ch_reg    <= '0;
      result_valid_reg <= 1'b0;
      scan_done_reg    <= 1'b0;
      timeout_err_reg  <= 1'b0;
    end else begin
      result_valid_reg <= 1'b0;
      scan_done_reg    <= 1'b0;
      // A timeout set later in this block overrides the clear.
      if (err_clr) begin
        timeout_err_reg <= 1'b0;
      end
      case (state_reg)
        ST_IDLE: begin
          if (enable) begin
            state_reg <= ST_WAIT_TICK;
          end
        end
        ST_WAIT_TICK: begin
          if (!enable) begin
            state_reg <= ST_IDLE;
          end else if (tick || pending) begin
            if (first_pick[2]) begin
              ch_reg    <= first_pick[1:0];
              state_reg <= ST_LOAD;
            end else begin
              scan_done_reg <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          cam_reg   <= cfg_msb(ch_reg, pga);
          cal_reg   <= cfg_lsb;
          write_reg <= I2C_ON;
          tmr_reg   <= '0;
          state_reg <= ST_REQ;
        end
        ST_REQ: begin
          if (i2c_busy) begin
            write_reg <= I2C_OFF;
            tmr_reg   <= '0;
            state_reg <= ST_XFER;
          end else if (tmr_reg == START_TO - 1) begin
            write_reg       <= I2C_OFF;
            stop_reg        <= I2C_ON;
            timeout_err_reg <= 1'b1;
            state_reg       <= ST_ABORT;
          end else begin
            tmr_reg <= tmr_reg + 32'd1;
          end
        end
        ST_XFER: begin
          // Entered only after busy was seen high, so low here is the falling edge.
          if (!i2c_busy) begin
            result_data_reg  <= {i2c_a0m, i2c_a0l};
            result_ch_reg    <= ch_reg;
            result_valid_reg <= 1'b1;
            state_reg        <= ST_STORE;
          end else if (tmr_reg == XFER_TO - 1) begin
            stop_reg        <= I2C_ON;
            timeout_err_reg <= 1'b1;
            state_reg       <= ST_ABORT;
          end else begin
            tmr_reg <= tmr_reg + 32'd1;
          end
        end
        ST_STORE: begin
          tmr_reg   <= '0;
          state_reg <= ST_SETTLE;
        end
        ST_ABORT: begin
          if (!i2c_busy) begin
            stop_reg  <= I2C_OFF;
            tmr_reg   <= '0;
            state_reg <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (tmr_reg == SETTLE - 1) begin
            tmr_reg <= '0;
            if (!enable) begin
              state_reg <= ST_IDLE;
            end else if (next_pick[2]) begin
              ch_reg    <= next_pick[1:0];
              state_reg <= ST_LOAD;
            end else begin
              scan_done_reg <= 1'b1;
              state_reg     <= ST_WAIT_TICK;
            end
          end else begin
            tmr_reg <= tmr_reg + 32'd1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign i2c_cam      = cam_reg;
  assign i2c_cal      = cal_reg;
  assign i2c_ad1      = DEV_ADDR;
  assign i2c_ad2      = CFG_PTR;
  assign i2c_ad3      = CONV_PTR;
  assign i2c_write    = write_reg;
  assign i2c_stop     = stop_reg;
  assign result_data  = result_data_reg;
  assign result_ch    = result_ch_reg;
  assign result_valid = result_valid_reg;
  assign scan_done    = scan_done_reg;
  assign timeout_err  = timeout_err_reg;

endmodule

// File: tb/tb_ads1115_scan_sequencer.sv
// Scoreboard bench: an I2C core model answers requests, the channel order is
// predicted from the mask, and a monitor checks every reported result.
module tb_ads1115_scan_sequencer;

  localparam int unsigned START_TO_TB = 20;
  localparam int unsigned XFER_TO_TB  = 50;
  localparam int unsigned SETTLE_TB   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] period;
  logic [3:0]  ch_mask;
  logic [2:0]  pga;
  logic [7:0]  cfg_lsb;
  logic        err_clr;
  logic        i2c_busy;
  logic [7:0]  i2c_a0m;
  logic [7:0]  i2c_a0l;
  logic [7:0]  i2c_cam, i2c_cal, i2c_ad1, i2c_ad2, i2c_ad3, i2c_write, i2c_stop;
  logic [15:0] result_data;
  logic [1:0]  result_ch;
  logic        result_valid, scan_done, timeout_err, seq_busy;

  always #5 clk = ~clk;

  ads1115_scan_sequencer #(
    .DEV_ADDR (8'h48),
    .START_TO (START_TO_TB),
    .XFER_TO  (XFER_TO_TB),
    .SETTLE   (SETTLE_TB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .period       (period),
    .ch_mask      (ch_mask),
    .pga          (pga),
    .cfg_lsb      (cfg_lsb),
    .err_clr      (err_clr),
    .i2c_busy     (i2c_busy),
    .i2c_a0m      (i2c_a0m),
    .i2c_a0l      (i2c_a0l),
    .i2c_cam      (i2c_cam),
    .i2c_cal      (i2c_cal),
    .i2c_ad1      (i2c_ad1),
    .i2c_ad2      (i2c_ad2),
    .i2c_ad3      (i2c_ad3),
    .i2c_write    (i2c_write),
    .i2c_stop     (i2c_stop),
    .result_data  (result_data),
    .result_ch    (result_ch),
    .result_valid (result_valid),
    .scan_done    (scan_done),
    .timeout_err  (timeout_err),
    .seq_busy     (seq_busy)
  );

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int req_cnt = 0;
  int ignore_cnt = 0;
  int stuck_cnt = 0;
  bit no_valid_chk = 1'b0;

  logic [3:0] cur_mask = 4'b0000;
  logic [2:0] cur_pga = 3'b001;
  logic [7:0] cur_lsb = 8'h83;
  int         chq[$];          // channels still expected in the current scan
  logic [17:0] sbq[$];         // expected {channel, data} results

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Result monitor.
  always @(negedge clk) begin
    logic [17:0] e;
    if (!reset) begin
      if (result_valid) begin
        check("result_expected", 32'(sbq.size() != 0), 32'd1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          check("result_data", 32'(result_data), 32'(e[15:0]));
          check("result_ch", 32'(result_ch), 32'(e[17:16]));
          $display("[TB] result ch=%0d data=%04h", result_ch, result_data);
        end
      end
      if (scan_done) begin
        done_cnt++;
        check("scan_done_after_last", 32'(chq.size() + sbq.size()), 32'd0);
      end
    end
  end

  // I2C core model: answers each write request according to the chosen mode.
  initial begin : bfm
    logic [1:0]  ch;
    logic [15:0] word;
    int          k, d, len;
    bit          ok;
    i2c_busy = 1'b0;
    i2c_a0m  = 8'h00;
    i2c_a0l  = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset && i2c_write == 8'h01) begin
        if (chq.size() == 0) begin
          for (int i = 0; i < 4; i++) if (cur_mask[i]) chq.push_back(i);
        end
        check("request_expected", 32'(chq.size() != 0), 32'd1);
        ch = 2'd0;
        if (chq.size() != 0) ch = 2'(chq.pop_front());
        check("cfg_msb", 32'(i2c_cam), 32'({2'b11, ch, cur_pga, 1'b1}));
        check("cfg_lsb", 32'(i2c_cal), 32'(cur_lsb));
        req_cnt++;
        $display("[TB] request ch=%0d cam=%02h cal=%02h", ch, i2c_cam, i2c_cal);
        if (ignore_cnt > 0) begin
          ignore_cnt--;
          k = 0;
          while (i2c_stop != 8'h01 && k < 200) begin @(negedge clk); k++; end
          check("start_timeout_cycles", k, START_TO_TB);
          check("timeout_err_set", 32'(timeout_err), 32'd1);
        end else if (stuck_cnt > 0) begin
          stuck_cnt--;
          i2c_busy = 1'b1;
          k = 0;
          while (i2c_stop != 8'h01 && k < 500) begin @(negedge clk); k++; end
          // XFER_TO busy-high samples inside XFER after the REQ edge that saw busy.
          check("xfer_timeout_cycles", k, XFER_TO_TB + 1);
          ok = 1'b1;
          repeat (10) begin
            @(negedge clk);
            if (i2c_stop != 8'h01) ok = 1'b0;
          end
          check("stop_held_while_busy", 32'(ok), 32'd1);
          i2c_busy = 1'b0;
          @(negedge clk);
          check("stop_released", 32'(i2c_stop), 32'd0);
        end else begin
          word = 16'($urandom);
          d    = int'($urandom_range(0, 3));
          len  = int'($urandom_range(5, 30));
          sbq.push_back({ch, word});
          repeat (d) @(negedge clk);
          i2c_a0m  = word[15:8];
          i2c_a0l  = word[7:0];
          i2c_busy = 1'b1;
          repeat (len) @(negedge clk);
          i2c_busy = 1'b0;
          @(negedge clk);
          if (!no_valid_chk) check("busy_fall_to_valid", 32'(result_valid), 32'd1);
        end
        k = 0;
        while (i2c_write != 8'h00 && k < 100) begin @(negedge clk); k++; end
      end
    end
  end

  task automatic wait_done(input int n, input int bound);
    int start, k;
    start = done_cnt;
    k = 0;
    while (done_cnt < start + n && k < bound) begin @(negedge clk); k++; end
    check("scan_done_wait", done_cnt - start, n);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (seq_busy && k < 500) begin @(negedge clk); k++; end
    check("idle_wait", 32'(seq_busy), 32'd0);
  endtask

  task automatic run_scans(input int n, input logic [31:0] per);
    ch_mask = cur_mask;
    pga     = cur_pga;
    cfg_lsb = cur_lsb;
    period  = per;
    chq.delete();
    enable  = 1'b1;
    wait_done(n, 4000);
    enable = 1'b0;
    wait_idle();
    check("scoreboard_drained", sbq.size(), 32'd0);
  endtask

  initial begin : main
    int k, s, w, dn;
    reset = 1'b1; enable = 1'b0; period = 32'd400; ch_mask = 4'b0000;
    pga = 3'b001; cfg_lsb = 8'h83; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cam", 32'(i2c_cam), 32'hC3);
    check("rst_cal", 32'(i2c_cal), 32'h83);
    check("rst_ad1", 32'(i2c_ad1), 32'h48);
    check("rst_ad2", 32'(i2c_ad2), 32'h01);
    check("rst_ad3", 32'(i2c_ad3), 32'h00);
    check("rst_write", 32'(i2c_write), 32'h00);
    check("rst_stop", 32'(i2c_stop), 32'h00);
    check("rst_result", 32'({result_ch, result_data}), 32'd0);
    check("rst_strobes", 32'({result_valid, scan_done}), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_seq_busy", 32'(seq_busy), 32'd0);
    reset = 1'b0;

    // Normal scans: first the reference pattern, then random masks and configs.
    for (int it = 0; it < 4; it++) begin
      if (it == 0) begin
        cur_mask = 4'b0101; cur_pga = 3'b001; cur_lsb = 8'h83;
      end else begin
        cur_mask = 4'($urandom_range(1, 15));
        cur_pga  = 3'($urandom);
        cur_lsb  = 8'($urandom);
      end
      run_scans(2, 32'd400);
    end

    // Core never answers the first request; the next channel must still run.
    cur_mask = 4'b0011; cur_pga = 3'b010; cur_lsb = 8'h83;
    ignore_cnt = 1;
    run_scans(1, 32'd400);
    check("ignore_consumed", ignore_cnt, 32'd0);
    check("timeout_err_sticky", 32'(timeout_err), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_clr", 32'(timeout_err), 32'd0);

    // Busy stuck high.
    cur_mask = 4'b0001;
    stuck_cnt = 1;
    run_scans(1, 32'd400);
    check("stuck_consumed", stuck_cnt, 32'd0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;

    // Short period: ticks during a scan collapse into one immediate rescan.
    cur_mask = 4'b0001; ch_mask = cur_mask; period = 32'd10;
    chq.delete();
    enable = 1'b1;
    k = 0;
    while (!scan_done && k < 500) begin @(negedge clk); k++; end
    check("first_scan_done", 32'(scan_done), 32'd1);
    period = 32'd100000;
    k = 0;
    do begin @(negedge clk); k++; end while (i2c_write != 8'h01 && k < 50);
    check("pending_restart_latency", k, 32'd2);
    wait_done(1, 2000);
    s = req_cnt;
    repeat (300) @(negedge clk);
    check("no_backlog_requests", req_cnt - s, 32'd0);
    enable = 1'b0;
    wait_idle();

    // Empty mask with period 1: scan_done every cycle, no transactions.
    cur_mask = 4'b0000; ch_mask = 4'b0000; period = 32'd1;
    chq.delete();
    enable = 1'b1;
    repeat (5) @(negedge clk);
    s = req_cnt; w = 0; dn = 0;
    repeat (20) begin
      @(negedge clk);
      if (i2c_write != 8'h00) w++;
      if (scan_done) dn++;
    end
    check("mask0_done_every_cycle", dn, 32'd20);
    check("mask0_no_write", w + req_cnt - s, 32'd0);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("scoreboard_final", sbq.size(), 32'd0);

    // Reset in the middle of a transfer.
    cur_mask = 4'b0001; ch_mask = 4'b0001; period = 32'd20;
    chq.delete();
    no_valid_chk = 1'b1;
    enable = 1'b1;
    k = 0;
    while (!i2c_busy && k < 200) begin @(negedge clk); k++; end
    check("xfer_reached", 32'(i2c_busy), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    check("rst_xfer_write", 32'(i2c_write), 32'h00);
    check("rst_xfer_cam", 32'(i2c_cam), 32'hC3);
    check("rst_xfer_seq_busy", 32'(seq_busy), 32'd0);
    k = 0;
    while (i2c_busy && k < 100) begin @(negedge clk); k++; end
    reset = 1'b0;
    sbq.delete();
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

endmodule
